// File: rtl/ddr_frame_reader_if.sv
// Read-request bus between the frame reader and the DDR controller:
// one request in flight, completed by a single-cycle acknowledge with data.
interface ddr_frame_reader_if;
  logic        read;
  logic [23:0] readAddress;
  logic        readAcknowledge;
  logic [15:0] readData;

  modport master (
    output read,
    output readAddress,
    input  readAcknowledge,
    input  readData
  );

  modport slave (
    input  read,
    input  readAddress,
    output readAcknowledge,
    output readData
  );
endinterface

// File: rtl/ddr_frame_reader.sv
// Streams FRAME_WORDS consecutive DDR words, one request at a time, into a
// first-word-fall-through pixel FIFO; frameStart restarts the fetch at any point.
module ddr_frame_reader #(
  parameter logic [23:0] BASE_ADDR   = 24'h000000,
  parameter int          FRAME_WORDS = 307200,
  parameter int          FIFO_DEPTH  = 16
) (
  input  logic               clk133_p,
  input  logic               rst,
  input  logic               frameStart,
  input  logic               pixelPop,
  output logic [15:0]        pixelData,
  output logic               pixelValid,
  output logic               underflow,
  output logic               busy,
  ddr_frame_reader_if.master ddr
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;

  localparam logic [CNT_W-1:0] LAST_WORD  = CNT_W'(FRAME_WORDS - 1);
  localparam logic [PTR_W:0]   FULL_LEVEL = (PTR_W + 1)'(FIFO_DEPTH);
  localparam logic [PTR_W:0]   ONE_SHORT  = (PTR_W + 1)'(FIFO_DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    HOLD,
    ABORT
  } state_t;

  state_t state;
  state_t state_next;

  logic [23:0]      addr;
  logic [CNT_W-1:0] word_count;

  logic [15:0]      mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   level;
  logic [PTR_W:0]   level_after_pop;

  logic push;
  logic pop;
  logic restart;
  logic advance;
  logic clear_underflow;

  assign pop             = pixelPop && pixelValid;
  assign level_after_pop = level - {{PTR_W{1'b0}}, pop};

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, regardless of statement order.
  always_ff @(posedge clk133_p or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // NOTE: every signal written here gets a default first, otherwise a path
  // that leaves it unassigned would infer a latch.
  always_comb begin
    state_next      = state;
    push            = 1'b0;
    advance         = 1'b0;
    restart         = 1'b0;
    clear_underflow = 1'b0;

    case (state)
      IDLE: begin
        if (frameStart) begin
          restart         = 1'b1;
          clear_underflow = 1'b1;
          state_next      = FETCH;
        end
      end

      FETCH: begin
        if (frameStart) begin
          // The in-flight request must still complete; its word is dropped.
          clear_underflow = 1'b1;
          if (ddr.readAcknowledge) begin
            restart    = 1'b1;
            state_next = FETCH;
          end else begin
            state_next = ABORT;
          end
        end else if (ddr.readAcknowledge) begin
          push    = 1'b1;
          advance = 1'b1;
          if (word_count == LAST_WORD) begin
            state_next = IDLE;
          end else if (level_after_pop == ONE_SHORT) begin
            state_next = HOLD;
          end else begin
            state_next = FETCH;
          end
        end
      end

      HOLD: begin
        if (frameStart) begin
          restart         = 1'b1;
          clear_underflow = 1'b1;
          state_next      = FETCH;
        end else if (level_after_pop != FULL_LEVEL) begin
          state_next = FETCH;
        end
      end

      ABORT: begin
        if (ddr.readAcknowledge) begin
          restart    = 1'b1;
          state_next = FETCH;
        end
      end

      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    ddr.read        = (state == FETCH) || (state == ABORT);
    ddr.readAddress = addr;
    busy            = (state != IDLE);
    pixelValid      = (level != '0);
    pixelData       = pixelValid ? mem[rd_ptr] : 16'h0000;
  end

  // Address, word counter, FIFO pointers and the sticky underflow flag.
  always_ff @(posedge clk133_p or negedge rst) begin
    if (!rst) begin
      addr       <= 24'h000000;
      word_count <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      underflow  <= 1'b0;
    end else begin
      if (restart) begin
        addr       <= BASE_ADDR;
        word_count <= '0;
        wr_ptr     <= '0;
        rd_ptr     <= '0;
        level      <= '0;
      end else begin
        if (advance) begin
          addr       <= addr + 24'd1;
          word_count <= word_count + CNT_W'(1);
        end
        if (push) begin
          wr_ptr <= wr_ptr + PTR_W'(1);
        end
        if (pop) begin
          rd_ptr <= rd_ptr + PTR_W'(1);
        end
        level <= level_after_pop + {{PTR_W{1'b0}}, push};
      end

      if (clear_underflow) begin
        underflow <= 1'b0;
      end else if (pixelPop && !pixelValid) begin
        underflow <= 1'b1;
      end
    end
  end

  // NOTE: FIFO storage has no reset; occupancy gates what is visible, so stale
  // contents are never observed and the array can map onto plain RAM.
  always_ff @(posedge clk133_p) begin
    if (push) begin
      mem[wr_ptr] <= ddr.readData;
    end
  end

endmodule

// File: tb/tb_ddr_frame_reader.sv
// Bench for ddr_frame_reader: three parameterisations checked every cycle
// against a transaction-level model of the frame fetch and the pixel queue.
module tb_ddr_frame_reader;

  localparam int NDUT = 3;

  logic clk;
  logic rst_n;

  logic        fs     [NDUT];
  logic        pop    [NDUT];
  logic        ack    [NDUT];
  logic [15:0] rdata  [NDUT];
  logic [15:0] pdata  [NDUT];
  logic        pvalid [NDUT];
  logic        uflow  [NDUT];
  logic        busy   [NDUT];
  logic        rd     [NDUT];
  logic [23:0] raddr  [NDUT];

  int checks;
  int errors;
  int dead_seen;

  // Reference model: frame activity, abort pending, accepted words, underflow.
  bit          m_active [NDUT];
  bit          m_abort  [NDUT];
  bit          m_uf     [NDUT];
  int          m_acks   [NDUT];
  logic [15:0] m_q      [NDUT][$];

  ddr_frame_reader_if bus0 ();
  ddr_frame_reader_if bus1 ();
  ddr_frame_reader_if bus2 ();

  assign bus0.readAcknowledge = ack[0];
  assign bus0.readData        = rdata[0];
  assign rd[0]                = bus0.read;
  assign raddr[0]             = bus0.readAddress;
  assign bus1.readAcknowledge = ack[1];
  assign bus1.readData        = rdata[1];
  assign rd[1]                = bus1.read;
  assign raddr[1]             = bus1.readAddress;
  assign bus2.readAcknowledge = ack[2];
  assign bus2.readData        = rdata[2];
  assign rd[2]                = bus2.read;
  assign raddr[2]             = bus2.readAddress;

  ddr_frame_reader #(.BASE_ADDR(24'h000000), .FRAME_WORDS(307200), .FIFO_DEPTH(16)) u_dut0 (
    .clk133_p(clk), .rst(rst_n), .frameStart(fs[0]), .pixelPop(pop[0]),
    .pixelData(pdata[0]), .pixelValid(pvalid[0]), .underflow(uflow[0]), .busy(busy[0]),
    .ddr(bus0)
  );

  ddr_frame_reader #(.BASE_ADDR(24'hFFFFFE), .FRAME_WORDS(4), .FIFO_DEPTH(16)) u_dut1 (
    .clk133_p(clk), .rst(rst_n), .frameStart(fs[1]), .pixelPop(pop[1]),
    .pixelData(pdata[1]), .pixelValid(pvalid[1]), .underflow(uflow[1]), .busy(busy[1]),
    .ddr(bus1)
  );

  ddr_frame_reader #(.BASE_ADDR(24'hFFFFF8), .FRAME_WORDS(20), .FIFO_DEPTH(4)) u_dut2 (
    .clk133_p(clk), .rst(rst_n), .frameStart(fs[2]), .pixelPop(pop[2]),
    .pixelData(pdata[2]), .pixelValid(pvalid[2]), .underflow(uflow[2]), .busy(busy[2]),
    .ddr(bus2)
  );

  initial clk = 1'b0;
  always #4 clk = ~clk;

  always @(negedge clk) begin
    if (pvalid[0] === 1'b1 && pdata[0] === 16'hDEAD) dead_seen++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired before the bench completed");
    $fatal(1);
  end

  function automatic logic [23:0] base_of(input int d);
    case (d)
      0:       return 24'h000000;
      1:       return 24'hFFFFFE;
      default: return 24'hFFFFF8;
    endcase
  endfunction

  function automatic int frame_words_of(input int d);
    case (d)
      0:       return 307200;
      1:       return 4;
      default: return 20;
    endcase
  endfunction

  function automatic int depth_of(input int d);
    return (d == 2) ? 4 : 16;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset(input int d);
    m_active[d] = 1'b0;
    m_abort[d]  = 1'b0;
    m_uf[d]     = 1'b0;
    m_acks[d]   = 0;
    m_q[d].delete();
  endtask

  task automatic model_restart(input int d);
    m_active[d] = 1'b1;
    m_abort[d]  = 1'b0;
    m_acks[d]   = 0;
    m_q[d].delete();
  endtask

  function automatic bit exp_read(input int d);
    return m_abort[d] || (m_active[d] && (m_q[d].size() < depth_of(d)));
  endfunction

  task automatic check_outputs(input int d);
    check($sformatf("d%0d_read", d), 32'(rd[d]), 32'(exp_read(d)));
    check($sformatf("d%0d_busy", d), 32'(busy[d]), 32'(m_active[d] || m_abort[d]));
    if (exp_read(d))
      check($sformatf("d%0d_addr", d), 32'(raddr[d]), 32'(24'(base_of(d) + 24'(m_acks[d]))));
    check($sformatf("d%0d_valid", d), 32'(pvalid[d]), 32'(m_q[d].size() > 0));
    if (m_q[d].size() > 0)
      check($sformatf("d%0d_data", d), 32'(pdata[d]), 32'(m_q[d][0]));
    check($sformatf("d%0d_underflow", d), 32'(uflow[d]), 32'(m_uf[d]));
  endtask

  // Applies the inputs about to be sampled to the model, using pre-edge state.
  task automatic model_update(input int d);
    bit fetching;
    bit was_empty;
    bit accepted;
    fetching  = !m_abort[d] && m_active[d] && (m_q[d].size() < depth_of(d));
    was_empty = (m_q[d].size() == 0);
    accepted  = 1'b0;
    if (pop[d] && !was_empty) void'(m_q[d].pop_front());
    if (m_abort[d]) begin
      if (ack[d]) model_restart(d);
    end else if (fetching) begin
      if (fs[d]) begin
        accepted = 1'b1;
        if (ack[d]) begin
          model_restart(d);
        end else begin
          m_abort[d]  = 1'b1;
          m_active[d] = 1'b0;
        end
      end else if (ack[d]) begin
        m_q[d].push_back(rdata[d]);
        m_acks[d]++;
        if (m_acks[d] == frame_words_of(d)) m_active[d] = 1'b0;
      end
    end else if (fs[d]) begin
      accepted = 1'b1;
      model_restart(d);
    end
    if (accepted) m_uf[d] = 1'b0;
    else if (pop[d] && was_empty) m_uf[d] = 1'b1;
  endtask

  // Called at a falling edge: check, commit the chosen inputs, advance a cycle.
  task automatic tick();
    for (int d = 0; d < NDUT; d++) check_outputs(d);
    if (rst_n) for (int d = 0; d < NDUT; d++) model_update(d);
    @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < NDUT; d++) begin
      fs[d]  = 1'b0;
      pop[d] = 1'b0;
      ack[d] = 1'b0;
    end
  endtask

  initial begin
    logic [23:0] exp_addr [4];
    logic [23:0] addr_log [4];
    logic [15:0] pix_log  [8];
    int acks;
    int npix;
    int age;
    int extra;
    bit last_checked;

    checks    = 0;
    errors    = 0;
    dead_seen = 0;
    rst_n     = 1'b0;
    for (int d = 0; d < NDUT; d++) begin
      fs[d] = 1'b0; pop[d] = 1'b0; ack[d] = 1'b0; rdata[d] = 16'h0000;
      model_reset(d);
    end

    repeat (2) @(negedge clk);
    for (int d = 0; d < NDUT; d++) begin
      check($sformatf("d%0d_rst_read", d),  32'(rd[d]),     32'd0);
      check($sformatf("d%0d_rst_addr", d),  32'(raddr[d]),  32'd0);
      check($sformatf("d%0d_rst_data", d),  32'(pdata[d]),  32'd0);
      check($sformatf("d%0d_rst_valid", d), 32'(pvalid[d]), 32'd0);
      check($sformatf("d%0d_rst_uflow", d), 32'(uflow[d]),  32'd0);
      check($sformatf("d%0d_rst_busy", d),  32'(busy[d]),   32'd0);
    end
    rst_n = 1'b1;
    tick();

    // Underflow is sticky until the next frameStart.
    pop[1] = 1'b1;
    tick();
    check("d1_underflow_set", 32'(uflow[1]), 32'd1);
    repeat (3) tick();
    check("d1_underflow_sticky", 32'(uflow[1]), 32'd1);

    // Four-word frame at the top of the address space, popped continuously.
    exp_addr[0] = 24'hFFFFFE;
    exp_addr[1] = 24'hFFFFFF;
    exp_addr[2] = 24'h000000;
    exp_addr[3] = 24'h000001;
    fs[1] = 1'b1;
    tick();
    check("d1_underflow_cleared", 32'(uflow[1]), 32'd0);
    acks = 0;
    npix = 0;
    last_checked = 1'b0;
    for (int c = 0; c < 60; c++) begin
      pop[1] = 1'b1;
      if (rd[1] && acks < 8) begin
        ack[1]   = 1'b1;
        rdata[1] = 16'h3210 + 16'(acks);
        if (acks < 4) addr_log[acks] = raddr[1];
        acks++;
      end
      if (pvalid[1] && npix < 8) begin
        pix_log[npix] = pdata[1];
        npix++;
      end
      tick();
      if (acks == 4 && !last_checked) begin
        check("d1_busy_after_last_ack", 32'(busy[1]), 32'd0);
        last_checked = 1'b1;
      end
      if (acks >= 4 && !pvalid[1] && !busy[1]) break;
    end
    check("d1_request_count", 32'(acks), 32'd4);
    check("d1_pixel_count", 32'(npix), 32'd4);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("d1_req_addr%0d", k), 32'(addr_log[k]), 32'(exp_addr[k]));
      check($sformatf("d1_pixel%0d", k), 32'(pix_log[k]), 32'(16'h3210 + 16'(k)));
    end
    extra = 0;
    repeat (5) begin
      if (rd[1]) extra++;
      tick();
    end
    check("d1_no_extra_request", 32'(extra), 32'd0);

    // Fill the 16-deep FIFO, acknowledging each request one cycle after it rises.
    fs[0] = 1'b1;
    tick();
    age  = 0;
    acks = 0;
    for (int c = 0; c < 200; c++) begin
      if (busy[0] && !rd[0]) break;
      if (rd[0]) begin
        if (age == 1) begin
          ack[0]   = 1'b1;
          rdata[0] = 16'(c);
          age      = 0;
          acks++;
        end else begin
          age = 1;
        end
      end
      tick();
    end
    check("d0_fill_requests", 32'(acks), 32'd16);
    check("d0_hold_read", 32'(rd[0]), 32'd0);
    tick();
    check("d0_hold_read_stays", 32'(rd[0]), 32'd0);
    pop[0] = 1'b1;
    tick();
    check("d0_resume_after_pop", 32'(rd[0]), 32'd1);

    // frameStart with a request outstanding; its late word must be discarded.
    fs[0] = 1'b1;
    tick();
    check("d0_abort_read_held", 32'(rd[0]), 32'd1);
    tick();
    tick();
    ack[0]   = 1'b1;
    rdata[0] = 16'hDEAD;
    tick();
    check("d0_abort_fifo_empty", 32'(pvalid[0]), 32'd0);
    check("d0_abort_restart_read", 32'(rd[0]), 32'd1);
    check("d0_abort_restart_addr", 32'(raddr[0]), 32'd0);
    for (int c = 0; c < 40; c++) begin
      pop[0] = 1'($urandom_range(0, 1));
      if (rd[0] && $urandom_range(0, 1) == 1) begin
        ack[0]   = 1'b1;
        rdata[0] = 16'($urandom_range(0, 16'hDEAC));
      end
      tick();
    end
    check("d0_dead_never_shown", 32'(dead_seen), 32'd0);

    // Reset in the middle of a request drops read at once.
    for (int c = 0; c < 20; c++) begin
      if (rd[0]) break;
      tick();
    end
    check("d0_pre_reset_read", 32'(rd[0]), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("d0_async_rst_read",  32'(rd[0]),     32'd0);
    check("d0_async_rst_addr",  32'(raddr[0]),  32'd0);
    check("d0_async_rst_data",  32'(pdata[0]),  32'd0);
    check("d0_async_rst_valid", 32'(pvalid[0]), 32'd0);
    check("d0_async_rst_uflow", 32'(uflow[0]),  32'd0);
    check("d0_async_rst_busy",  32'(busy[0]),   32'd0);
    for (int d = 0; d < NDUT; d++) model_reset(d);
    @(negedge clk);
    tick();
    rst_n = 1'b1;
    fs[0] = 1'b1;
    tick();
    check("d0_post_reset_read", 32'(rd[0]), 32'd1);
    check("d0_post_reset_addr", 32'(raddr[0]), 32'd0);
    for (int c = 0; c < 12; c++) begin
      pop[0] = 1'b1;
      if (rd[0]) begin
        ack[0]   = 1'b1;
        rdata[0] = 16'(16'h0100 + c);
      end
      tick();
    end

    // Randomised traffic: frames, restarts, aborts, stray acks and pops.
    fs[2] = 1'b1;
    tick();
    for (int c = 0; c < 4000; c++) begin
      fs[2]    = ($urandom_range(0, 99) == 0) || (!busy[2] && $urandom_range(0, 3) == 0);
      pop[2]   = 1'($urandom_range(0, 1));
      ack[2]   = ($urandom_range(0, 9) < 4);
      rdata[2] = 16'($urandom);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ddr_frame_reader.md
DDR_FRAME_READER -- requirements
Module: ddr_frame_reader

Interface
REQ-001 Parameter BASE_ADDR, 24'h000000, first word address of the frame in DDR.
REQ-002 Parameter FRAME_WORDS, 307200, 16-bit words fetched per frame (640x480).
REQ-003 Parameter FIFO_DEPTH, 16, pixel FIFO entries; power of two, at least 4.
REQ-004 clk133_p  in  1  sole clock; all logic on its rising edge.
REQ-005 rst  in  1  asynchronous, active-low reset (0 = reset asserted).
REQ-006 frameStart  in  1  one-cycle pulse that begins a new frame fetch.
REQ-007 pixelPop  in  1  consumer takes the head word this cycle.
REQ-008 pixelData  out  16  FIFO head word, first-word-fall-through.
REQ-009 pixelValid  out  1  FIFO not empty.
REQ-010 underflow  out  1  sticky flag; pixelPop was seen while FIFO was empty.
REQ-011 busy  out  1  high in every state except IDLE.
REQ-012 read  out  1  read request to the DDR controller.
REQ-013 readAddress  out  24  word address of the current request.
REQ-014 readAcknowledge  in  1  one-cycle pulse; readData is valid in the same cycle.
REQ-015 readData  in  16  word returned by the DDR controller.

Function
REQ-016 The block SHALL allow at most one request to be outstanding: once read rises, read and readAddress stay stable until the cycle in which readAcknowledge is sampled high.
REQ-017 The FSM SHALL have four states: IDLE, FETCH, HOLD and ABORT.
REQ-018 IDLE: read=0; on frameStart, load addr=BASE_ADDR and wordCount=0, flush the FIFO, clear underflow, then go to FETCH (HOLD if FIFO_DEPTH were 0, which is not allowed).
REQ-019 FETCH: read=1 and readAddress=addr; on readAcknowledge, push readData, then addr+1 and wordCount+1.
REQ-020 After that acknowledge, the next state is IDLE if wordCount reached FRAME_WORDS-1, else HOLD if the FIFO is then full, else FETCH (read stays high for back-to-back requests).
REQ-021 HOLD: read=0; go to FETCH on the first cycle the FIFO is not full.
REQ-022 Address arithmetic SHALL be modulo 2^24: 24'hFFFFFF+1 wraps to 24'h000000 with no error.
REQ-023 FIFO: a push happens only on readAcknowledge in FETCH; a pop happens only when pixelPop and pixelValid are both high.
REQ-024 Push and pop in the same cycle SHALL leave occupancy unchanged. Pointers wrap modulo FIFO_DEPTH.
REQ-025 A word pushed into an empty FIFO SHALL appear on pixelData with pixelValid=1 in the next cycle.
REQ-026 pixelPop with pixelValid=0 SHALL set underflow and change nothing else; underflow clears only on frameStart or reset.
REQ-027 frameStart in FETCH SHALL go to ABORT: read stays high, and the acknowledged word is discarded, not pushed.
REQ-028 ABORT then restarts as in REQ-018: flush, load BASE_ADDR, clear counters, enter FETCH.
REQ-029 frameStart in HOLD SHALL restart immediately, as in REQ-018.
REQ-030 frameStart in ABORT SHALL be ignored.
REQ-031 frameStart in the same cycle as a FETCH acknowledge SHALL discard that word and restart directly, without entering ABORT.
REQ-032 readAcknowledge outside FETCH and ABORT SHALL be ignored.

Reset
REQ-033 While rst=0, and immediately on assertion: state=IDLE, read=0, readAddress=0, pixelData=0, pixelValid=0, underflow=0, busy=0, FIFO empty, counters 0.
REQ-034 Reset asserted mid-request SHALL drop read without waiting for readAcknowledge.
REQ-035 Reset deassertion SHALL take effect on the next rising edge of clk133_p.

Verification
REQ-036 Reset, then frameStart; acknowledge each request one cycle after read rises -> addresses 0,1,2,... in order; FIFO fills to 16; read=0 in HOLD; one pop -> read rises the next cycle.
REQ-037 FRAME_WORDS=4, data 16'h3210, 16'h3211, 16'h3212, 16'h3213; pop continuously -> pixelData shows them in order; busy falls after the 4th acknowledge; exactly 4 requests issued.
REQ-038 BASE_ADDR=24'hFFFFFE, FRAME_WORDS=4 -> readAddress sequence FFFFFE, FFFFFF, 000000, 000001.
REQ-039 frameStart while read is high and no acknowledge yet; acknowledge 3 cycles later with 16'hDEAD -> 16'hDEAD never appears on pixelData; next request uses BASE_ADDR; FIFO empty.
REQ-040 pixelPop while FIFO is empty -> underflow=1 and stays high; next frameStart clears it.
REQ-041 Assert rst mid-FETCH -> all outputs at reset values in the same cycle; release rst plus frameStart -> normal fetch from BASE_ADDR.
